line_draw_engine: RTL and testbench
===================================

# line_draw_engine

Parametrised primitive-drawing engine for the graphics controller: given two endpoints, a colour and a command, it walks every pixel of a horizontal line, vertical line, arbitrary-octant Bresenham line or filled rectangle. It emits one frame-buffer byte write per pixel over a valid/ready port toward the SRAM arbiter. It replaces the hard-wired line states of the command state machine and adds rectangle fill, back-pressure and optional clipping.

## Interface
- COORD_W, 10, unsigned coordinate width
- COLOUR_W, 8, pixel width; one SRAM word holds two pixels (word = 2*COLOUR_W bits)
- SCREEN_W, 640, visible width in pixels (even)
- SCREEN_H, 480, visible height in pixels
- ADDR_W, 18, SRAM word-address width

- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Cmd  in  2  00 hline, 01 vline, 10 any line, 11 filled rect
- X1, Y1, X2, Y2  in  COORD_W each  endpoints (unsigned), latched on Start
- Colour  in  COLOUR_W  pixel value, latched on Start
- Busy  out  1  engine active
- Done  out  1  one-cycle pulse after last pixel accepted
- PixValid  out  1  pixel write request
- PixReady  in  1  arbiter accepts pixel when PixValid & PixReady
- PixAddr  out  ADDR_W  (Y*SCREEN_W + X) >> 1, truncated to ADDR_W
- PixUDS_L  out  1  0 when X even (upper byte)
- PixLDS_L  out  1  0 when X odd (lower byte)
- PixData  out  2*COLOUR_W  {Colour, Colour}

## Operation
- States: IDLE -> SETUP -> EMIT -> DONE -> IDLE. A CLIP state exists only under CLIP_EN (see Configuration).
- IDLE: Busy=0. Start=1 latches all inputs and moves to SETUP. Start while not in IDLE is ignored.
- SETUP (1 cycle): compute start point and step data per command.
  - hline: x from min(X1,X2) to max at Y1.
  - vline: y from min(Y1,Y2) to max at X1.
  - rect: row-major, y = min..max; each row x = min..max.
  - line: dx=|X2-X1|, dy=-|Y2-Y1|, sx/sy=±1, err=dx+dy. Signed, COORD_W+2 bits.
- EMIT: PixValid=1 for the current pixel. Advance only on handshake.
  - Line step: if current==(X2,Y2), go to DONE. Otherwise e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates use the pre-step err.
  - Other commands go to DONE after the final pixel's handshake.
- DONE: Done=1, Busy=1 for one cycle, then IDLE.
- Point case (X1=X2 and Y1=Y2): exactly one pixel for every Cmd.
- Pixel counts: hline |dX|+1; vline |dY|+1; rect (|dX|+1)*(|dY|+1); line max(|dX|,|dY|)+1.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, PixValid 0, PixAddr 0, PixUDS_L 1, PixLDS_L 1, PixData 0.
- Reset mid-operation aborts immediately. No Done is generated and PixValid drops asynchronously.
- Start accepted at edge k: Busy=1 from k+1; first PixValid at k+2.
- With PixReady held high, one pixel per cycle. Done is asserted in the cycle after the last handshake; Busy falls with it on the following edge.
- While PixValid=1 and PixReady=0, PixAddr, PixUDS_L, PixLDS_L and PixData hold stable. PixValid never drops without a handshake.
- The earliest next Start is accepted one cycle after Done.

## Configuration
- GFX_CLIP_EN defined: pixels with X>=SCREEN_W or Y>=SCREEN_H are skipped.
  - A skipped pixel takes one internal cycle with PixValid=0 and consumes no handshake.
  - A fully clipped primitive still ends with Done.
- Undefined: every pixel is emitted; the address is truncated to ADDR_W bits with no bounds check.

## Test plan
- Hline (10,5)-(13,5), Colour 0x22 -> 4 handshakes:
  - addr 1605 UDS_L=0; 1605 LDS_L=0; 1606 UDS_L=0; 1606 LDS_L=0.
  - PixData 0x2222 throughout; one Done.
- Line (100,100)-(150,150), Colour 2 -> 51 diagonal pixels.
  - First addr 32050 (UDS); last addr 48075 (UDS).
  - First PixValid 2 cycles after Start; Done 1 cycle after 51st handshake.
- Steep reversed line (3,10)-(1,4) -> 7 pixels, y strictly decreasing 10..4, x non-increasing from 3 to 1, ending exactly at (1,4).
- Rect (0,0)-(2,1) with PixReady low 5 cycles after first PixValid -> outputs stable while stalled; 6 pixels in row-major order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); none lost or duplicated.
- Point (7,7), each Cmd -> exactly 1 pixel at addr 2243 LDS_L=0. A second Start pulsed while Busy is ignored.
- Reset asserted mid-line -> PixValid 0 at once, Busy 0, no Done. Line (638,0)-(641,0) gives 2 pixels with GFX_CLIP_EN and 4 without.

Source files
------------

// File: rtl/line_draw_engine.sv
// line_draw_engine: walks the pixels of a horizontal line, vertical line,
// Bresenham line or filled rectangle and issues one frame-buffer byte write
// per pixel over a valid/ready port.
// Optional build macro GFX_CLIP_EN: pixels outside SCREEN_W x SCREEN_H are
// skipped, one internal cycle each, without a handshake.
module line_draw_engine #(
   parameter int unsigned COORD_W  = 10,
   parameter int unsigned COLOUR_W = 8,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned ADDR_W   = 18
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [1:0]            cmd_i,
   input  logic [COORD_W-1:0]    x1_i,
   input  logic [COORD_W-1:0]    y1_i,
   input  logic [COORD_W-1:0]    x2_i,
   input  logic [COORD_W-1:0]    y2_i,
   input  logic [COLOUR_W-1:0]   colour_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pix_valid_o,
   input  logic                  pix_ready_i,
   output logic [ADDR_W-1:0]     pix_addr_o,
   output logic                  pix_uds_l_o,
   output logic                  pix_lds_l_o,
   output logic [2*COLOUR_W-1:0] pix_data_o
);

   localparam int unsigned EW = COORD_W + 2;
   localparam logic [1:0] CMD_HLINE = 2'b00;
   localparam logic [1:0] CMD_VLINE = 2'b01;
   localparam logic [1:0] CMD_LINE  = 2'b10;
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_EMIT, S_DONE
`ifdef GFX_CLIP_EN
      , S_CLIP
`endif
   } state_t;

   state_t state_q, state_d;
   logic [1:0]          cmd_q, cmd_d;
   logic [COORD_W-1:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]  x_start_q, x_start_d, x_end_q, x_end_d, y_end_q, y_end_d;
   logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

   logic [COORD_W-1:0]  x_min, x_max, y_min, y_max, adx, ady;
   logic signed [EW:0]  e2, dy_ext, dx_ext;
   logic                step_x, step_y, advance;
   logic [ADDR_W:0]     lin_addr;

   // Endpoint ordering and absolute deltas from the latched command
   always_comb begin
      x_min = (x1_q <= x2_q) ? x1_q : x2_q;
      x_max = (x1_q <= x2_q) ? x2_q : x1_q;
      y_min = (y1_q <= y2_q) ? y1_q : y2_q;
      y_max = (y1_q <= y2_q) ? y2_q : y1_q;
      adx   = x_max - x_min;
      ady   = y_max - y_min;
      // Bresenham decisions, both taken from the pre-step error term
      e2     = $signed({err_q, 1'b0});
      dy_ext = $signed({dy_q[EW-1], dy_q});
      dx_ext = $signed({dx_q[EW-1], dx_q});
      step_x = (e2 >= dy_ext);
      step_y = (e2 <= dx_ext);
   end

   // Next-state and walk logic
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      colour_d  = colour_q;
      x_d       = x_q;
      y_d       = y_q;
      x_start_d = x_start_q;
      x_end_d   = x_end_q;
      y_end_d   = y_end_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      err_d     = err_q;
      sx_neg_d  = sx_neg_q;
      sy_neg_d  = sy_neg_q;
      advance   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cmd_d    = cmd_i;
               x1_d     = x1_i;
               y1_d     = y1_i;
               x2_d     = x2_i;
               y2_d     = y2_i;
               colour_d = colour_i;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cmd_q == CMD_LINE) begin
               x_d       = x1_q;
               y_d       = y1_q;
               x_start_d = x1_q;
               x_end_d   = x2_q;
               y_end_d   = y2_q;
               dx_d      = $signed({2'b00, adx});
               dy_d      = -$signed({2'b00, ady});
               err_d     = $signed({2'b00, adx}) - $signed({2'b00, ady});
               sx_neg_d  = (x2_q < x1_q);
               sy_neg_d  = (y2_q < y1_q);
            end else begin
               // hline/vline are rectangles collapsed to one row or column
               x_d       = (cmd_q == CMD_VLINE) ? x1_q : x_min;
               x_start_d = (cmd_q == CMD_VLINE) ? x1_q : x_min;
               x_end_d   = (cmd_q == CMD_VLINE) ? x1_q : x_max;
               y_d       = (cmd_q == CMD_HLINE) ? y1_q : y_min;
               y_end_d   = (cmd_q == CMD_HLINE) ? y1_q : y_max;
            end
            state_d = S_EMIT;
         end
         S_EMIT:  advance = pix_ready_i;
`ifdef GFX_CLIP_EN
         S_CLIP:  advance = 1'b1;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (x_q == x_end_q && y_q == y_end_q) begin
            state_d = S_DONE;
         end else begin
            if (cmd_q == CMD_LINE) begin
               err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
               if (step_x) x_d = sx_neg_q ? x_q - C_ONE : x_q + C_ONE;
               if (step_y) y_d = sy_neg_q ? y_q - C_ONE : y_q + C_ONE;
            end else if (x_q == x_end_q) begin
               x_d = x_start_q;
               y_d = y_q + C_ONE;
            end else begin
               x_d = x_q + C_ONE;
            end
            state_d = S_EMIT;
         end
      end

`ifdef GFX_CLIP_EN
      // Off-screen pixels are walked in CLIP instead of being offered
      if (state_d == S_EMIT && !((32'(x_d) < SCREEN_W) && (32'(y_d) < SCREEN_H)))
         state_d = S_CLIP;
`endif
   end

   // State and datapath registers; reset aborts any primitive in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         colour_q  <= '0;
         x_q       <= '0;
         y_q       <= '0;
         x_start_q <= '0;
         x_end_q   <= '0;
         y_end_q   <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         err_q     <= '0;
         sx_neg_q  <= 1'b0;
         sy_neg_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         colour_q  <= colour_d;
         x_q       <= x_d;
         y_q       <= y_d;
         x_start_q <= x_start_d;
         x_end_q   <= x_end_d;
         y_end_q   <= y_end_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         err_q     <= err_d;
         sx_neg_q  <= sx_neg_d;
         sy_neg_q  <= sy_neg_d;
      end
   end

   // Pixel port decoded straight from registers, so it holds during a stall
   always_comb begin
      lin_addr    = (ADDR_W+1)'(32'(y_q) * SCREEN_W + 32'(x_q));
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE);
      pix_valid_o = (state_q == S_EMIT);
      pix_addr_o  = lin_addr[ADDR_W:1];
      pix_uds_l_o = ~(pix_valid_o & ~lin_addr[0]);
      pix_lds_l_o = ~(pix_valid_o & lin_addr[0]);
      pix_data_o  = {colour_q, colour_q};
   end

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed bench for line_draw_engine: hline, diagonal and steep lines,
// stalled rectangle, point per command, mid-run reset and screen-edge line.
module tb_line_draw_engine;

   logic        clk = 1'b0;
   logic        rst, start, ready;
   logic [1:0]  cmd;
   logic [9:0]  x1, y1, x2, y2;
   logic [7:0]  colour;
   logic        busy, done, pix_valid, uds_l, lds_l;
   logic [17:0] addr;
   logic [15:0] data;

   line_draw_engine dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_i(cmd),
      .x1_i(x1), .y1_i(y1), .x2_i(x2), .y2_i(y2), .colour_i(colour),
      .busy_o(busy), .done_o(done), .pix_valid_o(pix_valid),
      .pix_ready_i(ready), .pix_addr_o(addr), .pix_uds_l_o(uds_l),
      .pix_lds_l_o(lds_l), .pix_data_o(data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int first_v_cyc = -1;
   int last_hs_cyc = 0;
   logic [31:0] pix_q[$];
   logic [15:0] dat_q[$];

   always @(posedge clk) cyc++;

   // Handshake monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (pix_valid && ready) begin
         pix_q.push_back({12'd0, uds_l, lds_l, addr});
         dat_q.push_back(data);
         last_hs_cyc = cyc;
         $display("pix %0d addr=%0d uds_l=%0b lds_l=%0b data=%h", pix_q.size(), addr, uds_l, lds_l, data);
      end
      if (pix_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d (0x%h) want=%0d (0x%h)", tag, got, got, exp, exp);
      end
   endtask

   // Expected record for linear pixel index y*640+x
   function automatic logic [31:0] rec(input logic [31:0] l);
      return {12'd0, l[0], ~l[0], l[18:1]};
   endfunction

   task automatic chk_pix(input string tag, input int idx, input logic [31:0] lin);
      logic [31:0] got;
      got = (idx < pix_q.size()) ? pix_q[idx] : 32'hdeadbeef;
      chk(tag, got, rec(lin));
   endtask

   task automatic clear_mon();
      pix_q.delete();
      dat_q.delete();
      done_cnt = 0;
      first_v_cyc = -1;
   endtask

   // Pulses Start for one cycle; s is the cycle in which Start was high
   task automatic launch(input logic [1:0] c, input int a, input int b, input int cc,
                         input int d, input logic [7:0] col, output int s);
      @(posedge clk); #1;
      cmd = c; x1 = a[9:0]; y1 = b[9:0]; x2 = cc[9:0]; y2 = d[9:0]; colour = col;
      start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   int s;
   int errs;
   logic [31:0] stall_rec;
   logic [31:0] cur;
   logic [31:0] steep[7] = '{6403, 5763, 5122, 4482, 3842, 3201, 2561};
   logic [31:0] rect[6] = '{0, 1, 2, 640, 641, 642};

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b1; cmd = 2'b00;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0; colour = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_addr", addr, 0);
      chk("rst_uds", uds_l, 1);
      chk("rst_lds", lds_l, 1);
      chk("rst_data", data, 0);
      rst = 1'b0;

      // Horizontal line, byte lanes alternate
      clear_mon();
      launch(2'b00, 10, 5, 13, 5, 8'h22, s);
      wait_done("hl");
      chk("hl_count", pix_q.size(), 4);
      for (int i = 0; i < 4; i++) chk_pix("hl_pix", i, 3210 + i);
      for (int i = 0; i < 4; i++) chk("hl_data", (i < dat_q.size()) ? dat_q[i] : 16'h0, 16'h2222);

      // 45-degree line with latency checks
      clear_mon();
      launch(2'b10, 100, 100, 150, 150, 8'h02, s);
      chk("ln_busy_early", busy, 1);
      chk("ln_valid_early", pix_valid, 0);
      wait_done("ln");
      chk("ln_count", pix_q.size(), 51);
      chk_pix("ln_first", 0, 64100);
      chk_pix("ln_last", 50, 96150);
      errs = 0;
      for (int i = 0; i < 51; i++)
         if (i >= pix_q.size() || pix_q[i] != rec((100 + i) * 641)) errs++;
      chk("ln_diag", errs, 0);
      chk("ln_first_lat", first_v_cyc - s, 2);
      chk("ln_done_lat", done_cyc - last_hs_cyc, 1);

      // Steep line walked right-to-left and bottom-to-top
      clear_mon();
      launch(2'b10, 3, 10, 1, 4, 8'h33, s);
      wait_done("st");
      chk("st_count", pix_q.size(), 7);
      for (int i = 0; i < 7; i++) chk_pix("st_pix", i, steep[i]);

      // Rectangle with a five-cycle stall on the first pixel
      clear_mon();
      ready = 1'b0;
      launch(2'b11, 0, 0, 2, 1, 8'h5a, s);
      for (int n = 0; n < 20 && !pix_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("rc_valid", pix_valid, 1);
      stall_rec = {uds_l, lds_l, addr, data[11:0]};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         cur = {uds_l, lds_l, addr, data[11:0]};
         chk("rc_stall_valid", pix_valid, 1);
         chk("rc_stall_hold", cur, stall_rec);
      end
      ready = 1'b1;
      wait_done("rc");
      chk("rc_count", pix_q.size(), 6);
      for (int i = 0; i < 6; i++) chk_pix("rc_pix", i, rect[i]);
      chk("rc_data", (dat_q.size() > 0) ? dat_q[0] : 16'h0, 16'h5a5a);

      // Single point for every command; the rect one gets a second Start
      for (int c = 0; c < 4; c++) begin
         clear_mon();
         launch(c[1:0], 7, 7, 7, 7, 8'h11, s);
         if (c == 3) begin
            x1 = 10'd20; y1 = 10'd20; x2 = 10'd30; y2 = 10'd30;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         wait_done("pt");
         repeat (4) @(posedge clk);
         #1;
         chk("pt_count", pix_q.size(), 1);
         chk_pix("pt_pix", 0, 4487);
         chk("pt_idle", busy, 0);
      end

      // Reset in the middle of a line
      clear_mon();
      launch(2'b10, 100, 100, 150, 150, 8'h44, s);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_valid", pix_valid, 0);
      chk("ar_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("ar_no_done", done_cnt, 0);
      chk("ar_idle", busy, 0);

      // Line across the right screen edge
      clear_mon();
      launch(2'b10, 638, 0, 641, 0, 8'h01, s);
      wait_done("cl");
      chk_pix("cl_pix0", 0, 638);
      chk_pix("cl_pix1", 1, 639);
`ifdef GFX_CLIP_EN
      chk("cl_count", pix_q.size(), 2);
`else
      chk("cl_count", pix_q.size(), 4);
      chk_pix("cl_pix2", 2, 640);
      chk_pix("cl_pix3", 3, 641);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
